result_fifo: RTL and testbench
==============================

Name: result_fifo

Overview:
- Buffers sampler results downstream of offset_sampler.
- Captures each result word when result_ready pulses and holds it for the SPI register interface, so that back-to-back runs are not lost between host reads.
- The register logic reads the oldest entry through the result register and pops it.
- Occupancy, overflow and drop statistics are exposed for the control/status register.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2
- WIDTH, 32, result word width
- DROP_WIDTH, 16, width of the saturating dropped-result counter

Ports:
- clk  in  1  system clock (ETS clkgen output domain)
- reset  in  1  synchronous, active-high reset
- result_ready  in  1  single-cycle strobe from offset_sampler: result is valid
- result  in  WIDTH  sampler result word
- pop  in  1  single-cycle strobe from register logic: consume the head entry
- clear  in  1  single-cycle strobe: flush contents and statistics
- head_word  out  WIDTH  oldest buffered entry; 0 when empty
- empty  out  1  no entries buffered
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  number of buffered entries
- overflow  out  1  sticky: at least one result was dropped since the last clear/reset
- dropped_count  out  DROP_WIDTH  number of dropped results, saturating at all-ones

Behaviour:
- Storage: circular buffer of DEPTH words with wr_ptr and rd_ptr of $clog2(DEPTH) bits; both pointers wrap modulo DEPTH.
- count is a separate register; empty = (count == 0) and full = (count == DEPTH), both decoded from registered state.
- All outputs are driven from registered state only; there is no combinational path from any input to any output.
- head_word = mem[rd_ptr] when count != 0, otherwise 0.
- Reset (or clear): pointers = 0, count = 0, empty = 1, full = 0, overflow = 0, dropped_count = 0, head_word = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries.
- Priority order per cycle: reset > clear > push/pop.
  - A result_ready coincident with clear is discarded and is not counted as dropped.
- Push (result_ready = 1, not full, or full with a simultaneous valid pop): write result to mem[wr_ptr], then increment wr_ptr.
- Pop (pop = 1 and count != 0): increment rd_ptr. A pop while empty is ignored and raises no error flag.
- Count update:
  - push only: count + 1
  - pop only: count - 1
  - push and pop in the same cycle: count unchanged
- Full with simultaneous push and pop: both succeed; count stays at DEPTH and overflow is not set.
- Empty with simultaneous push and pop: the pop is ignored and the push is accepted; count becomes 1.
- Drop (result_ready = 1, full, no pop): result is discarded; overflow <= 1; dropped_count increments unless already all-ones.
- Latency:
  - push at edge N: empty deasserts, count updates and head_word shows the new entry after edge N (visible in cycle N+1).
  - pop at edge N: head_word shows the next entry, or 0, in cycle N+1.
- Ordering: strict FIFO; no reordering and no duplication.
- The register logic asserts pop in the cycle after it latches head_word into word_to_output for a result-register read.

Decomposition:
- Shared package picoview_pkg holds:
  - the register index constants (REG_CONTROL .. REG_POST_INPUT, REG_ID);
  - control/status bit positions, including the new STATUS_BIT_FIFO_EMPTY, STATUS_BIT_FIFO_FULL and STATUS_BIT_FIFO_OVERFLOW;
  - RESULT_FIFO_DEPTH.
- One sub-module is natural: sat_counter (parameterised width, synchronous clear, enable, saturates at all-ones), used for dropped_count.
- Pointer and count logic stay inline.

Test Plan:
- Reset, then idle for 5 cycles -> empty = 1, full = 0, count = 0, head_word = 0, overflow = 0, dropped_count = 0.
- Push 32'h00000011 and 32'h00000022 on consecutive cycles, then pop twice -> head_word is 11 then 22 then 0; count goes 1, 2, 1, 0; empty = 1 at the end.
- Push 17 words 1..17 with DEPTH = 16 -> full = 1 after word 16; word 17 dropped; overflow = 1, dropped_count = 1; draining pops return 1..16 in order.
- With the FIFO full, assert result_ready and pop in the same cycle with result = 32'hAAAA5555 -> count stays 16, overflow stays 0, and the last entry popped is AAAA5555.
- With the FIFO empty, assert pop and result_ready (32'hC001CAFE) together -> count = 1, head_word = C001CAFE next cycle; then assert clear together with result_ready -> count = 0, dropped_count unchanged.
- Force 70000 drops while full -> dropped_count saturates at 16'hFFFF; assert reset in the middle of a push/pop stream -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/picoview_pkg.sv
// picoview_pkg
// Shared constants for the picoview control block: register indices used by
// the SPI register logic, control/status bit positions, and the depth of the
// sampler result FIFO.
package picoview_pkg;

  // Register indices
  localparam logic [3:0] REG_CONTROL    = 4'h0;
  localparam logic [3:0] REG_STATUS     = 4'h1;
  localparam logic [3:0] REG_RESULT     = 4'h2;
  localparam logic [3:0] REG_PRE_INPUT  = 4'h3;
  localparam logic [3:0] REG_POST_INPUT = 4'h4;
  localparam logic [3:0] REG_ID         = 4'hF;

  // Control register bit positions
  localparam int CONTROL_BIT_RUN        = 0;
  localparam int CONTROL_BIT_FIFO_CLEAR = 1;

  // Status register bit positions
  localparam int STATUS_BIT_BUSY          = 0;
  localparam int STATUS_BIT_FIFO_EMPTY    = 1;
  localparam int STATUS_BIT_FIFO_FULL     = 2;
  localparam int STATUS_BIT_FIFO_OVERFLOW = 3;

  // Result FIFO sizing
  localparam int RESULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset (count to 0)
//   clear  - synchronous clear (count to 0), same effect as reset
//   en     - count-up enable for this cycle
//   value  - current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (en && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/result_fifo.sv
// result_fifo
// Circular buffer holding sampler results until the register logic reads
// them, so back-to-back sampler runs are not lost between host reads.
// Ports:
//   clk           - system clock
//   reset         - synchronous, active-high reset
//   result_ready  - strobe: result is valid and should be captured
//   result        - sampler result word
//   pop           - strobe: consume the head entry
//   clear         - strobe: flush contents and statistics
//   head_word     - oldest buffered entry, 0 when empty
//   empty / full  - occupancy flags
//   count         - number of buffered entries
//   overflow      - sticky: a result was dropped since last clear/reset
//   dropped_count - saturating count of dropped results
module result_fifo
  import picoview_pkg::*;
#(
  parameter int DEPTH      = RESULT_FIFO_DEPTH,
  parameter int WIDTH      = 32,
  parameter int DROP_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     result_ready,
  input  logic [WIDTH-1:0]         result,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_word,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_WIDTH-1:0]    dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic pop_ok;
  logic push_ok;
  logic drop;
  logic flush;

  assign flush = reset || clear;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when a valid pop coincides with it.
  assign pop_ok  = pop && !empty;
  assign push_ok = result_ready && (!full || pop_ok);
  assign drop    = result_ready && full && !pop_ok;

  assign head_word = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately not reset; only the pointers and count are.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (DROP_WIDTH)
  ) u_drop_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (drop),
    .value (dropped_count)
  );

endmodule

// File: tb/tb_result_fifo.sv
module tb_result_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int DROPW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] head_word;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             overflow;
  logic [DROPW-1:0] dropped_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .DROP_WIDTH (DROPW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .result_ready  (result_ready),
    .result        (result),
    .pop           (pop),
    .clear         (clear),
    .head_word     (head_word),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    result_ready = 1'b1;
    result       = w;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic pop_word();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_empty"},   32'(empty),         32'd1);
    check({pfx, "_full"},    32'(full),          32'd0);
    check({pfx, "_count"},   32'(count),         32'd0);
    check({pfx, "_head"},    head_word,          32'd0);
    check({pfx, "_ovf"},     32'(overflow),      32'd0);
    check({pfx, "_dropped"}, 32'(dropped_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; result_ready = 1'b0; result = '0; pop = 1'b0; clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check_reset_state("rst");

    // Two pushes then two pops
    push_word(32'h00000011);
    check("p1_count", 32'(count), 32'd1);
    check("p1_head",  head_word,  32'h11);
    check("p1_empty", 32'(empty), 32'd0);
    push_word(32'h00000022);
    check("p2_count", 32'(count), 32'd2);
    check("p2_head",  head_word,  32'h11);
    pop_word();
    check("q1_count", 32'(count), 32'd1);
    check("q1_head",  head_word,  32'h22);
    pop_word();
    check("q2_count", 32'(count), 32'd0);
    check("q2_head",  head_word,  32'h0);
    check("q2_empty", 32'(empty), 32'd1);
    pop_word();
    check("pop_empty_count", 32'(count), 32'd0);
    check("pop_empty_ovf",   32'(overflow), 32'd0);

    // Fill past capacity: word 17 is dropped
    for (int i = 1; i <= 17; i++) begin
      push_word(32'(i));
      if (i == 15) check("fill15_full", 32'(full), 32'd0);
      if (i == 16) check("fill16_full", 32'(full), 32'd1);
    end
    check("ovf_count",   32'(count),         32'd16);
    check("ovf_flag",    32'(overflow),      32'd1);
    check("ovf_dropped", 32'(dropped_count), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_%0d", i), head_word, 32'(i));
      pop_word();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Clear flushes statistics
    do_clear();
    check("clr_ovf",     32'(overflow),      32'd0);
    check("clr_dropped", 32'(dropped_count), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    check("fp_full", 32'(full), 32'd1);
    result_ready = 1'b1; result = 32'hAAAA5555; pop = 1'b1;
    tick();
    result_ready = 1'b0; pop = 1'b0;
    check("fp_count", 32'(count),    32'd16);
    check("fp_ovf",   32'(overflow), 32'd0);
    check("fp_head",  head_word,     32'h101);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fp_drain_%0d", i), head_word, 32'h100 + 32'(i));
      pop_word();
    end
    check("fp_last", head_word, 32'hAAAA5555);
    pop_word();
    check("fp_end_empty", 32'(empty), 32'd1);

    // Empty with simultaneous push and pop
    result_ready = 1'b1; result = 32'hC001CAFE; pop = 1'b1;
    tick();
    result_ready = 1'b0; pop = 1'b0;
    check("ep_count", 32'(count), 32'd1);
    check("ep_head",  head_word,  32'hC001CAFE);

    // Clear coincident with result_ready: push discarded, not counted as drop
    clear = 1'b1; result_ready = 1'b1; result = 32'h12345678;
    tick();
    clear = 1'b0; result_ready = 1'b0;
    check("cp_count",   32'(count),         32'd0);
    check("cp_head",    head_word,          32'd0);
    check("cp_dropped", 32'(dropped_count), 32'd0);
    tick();
    check("cp_count_after", 32'(count), 32'd0);

    // Saturate the drop counter
    for (int i = 0; i < 16; i++) push_word(32'h200 + 32'(i));
    result_ready = 1'b1; result = 32'hDEAD0000;
    repeat (3) tick();
    check("sat_3", 32'(dropped_count), 32'd3);
    repeat (69997) tick();
    result_ready = 1'b0;
    check("sat_value", 32'(dropped_count), 32'hFFFF);
    check("sat_ovf",   32'(overflow),      32'd1);
    check("sat_count", 32'(count),         32'd16);
    check("sat_head",  head_word,          32'h200);

    // Reset in the middle of a push/pop stream
    result_ready = 1'b1; pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      result = 32'h300 + 32'(i);
      tick();
    end
    check("stream_count", 32'(count), 32'd16);
    reset = 1'b1;
    tick();
    check_reset_state("midrst");
    reset = 1'b0; result_ready = 1'b0; pop = 1'b0;
    tick();
    check_reset_state("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
